bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single multiplexed AddrData bus, and the `mem_controller` behind it, between several processor-side requesters. It grants the bus to exactly one requester at a time and holds the grant for one complete burst transaction (address phase plus 4 data words). It tracks the burst by monitoring the shared `AddrValid` and `rw` lines, then inserts one idle turnaround cycle before re-arbitrating. It sits between the requesting masters and the bus/memory-controller side of the design.

---
 rtl/bus_arbiter_pkg.sv | 19 +
 rtl/bus_arbiter_if.sv | 34 +++
 rtl/bus_arbiter_rr_picker.sv | 38 +++
 rtl/bus_arbiter.sv | 115 +++++++++++
 tb/tb_bus_arbiter.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the bus arbiter slice.
// Contents:
//   arb_state_t      - arbiter FSM state encoding
//   BURST_DEFAULT    - data words per burst transaction
//   TIMEOUT_DEFAULT  - cycles a grantee may idle before losing the grant
package bus_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT  = 3'd1,
        RDWAIT = 3'd2,
        DATA   = 3'd3,
        TURN   = 3'd4
    } arb_state_t;

    localparam int BURST_DEFAULT   = 4;
    localparam int TIMEOUT_DEFAULT = 8;

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester/bus side signals of the bus arbiter.
// Signals:
//   req       - level request lines, one per requester
//   AddrValid - shared-bus address strobe from the granted master
//   rw        - shared-bus direction (1 = read, 0 = write)
//   gnt       - one-hot registered grant
//   owner     - index of the current or most recent grantee
//   busy      - arbiter not idle
//   timeout   - one-cycle pulse when a grant is revoked for inactivity
// Modports: master (requesters / bus masters), slave (arbiter).
interface bus_arbiter_if #(
    parameter int NREQ = 2
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] req;
    logic            AddrValid;
    logic            rw;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   owner;
    logic            busy;
    logic            timeout;

    modport master (
        output req, AddrValid, rw,
        input  gnt, owner, busy, timeout
    );

    modport slave (
        input  req, AddrValid, rw,
        output gnt, owner, busy, timeout
    );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin selector.
// Ports:
//   req        in  NREQ  - request lines
//   last_owner in  IW    - most recent grantee; search starts one above it
//   valid      out 1     - at least one request present
//   winner     out IW    - index of the selected requester
//   onehot     out NREQ  - one-hot form of winner (zero when !valid)
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_owner,
    output logic            valid,
    output logic [IW-1:0]   winner,
    output logic [NREQ-1:0] onehot
);

    logic [IW-1:0] cand;

    assign valid = |req;

    // Walk the candidates from farthest to nearest so the nearest requester
    // after last_owner is the final (winning) assignment.
    always_comb begin
        cand   = '0;
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = IW'((int'(last_owner) + 1 + i) % NREQ);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    assign onehot = valid ? (NREQ'(1) << winner) : '0;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared multiplexed AddrData bus.
// Grants one requester at a time for a full burst (address phase plus
// BURST data words), tracking the burst from AddrValid/rw, then inserts one
// idle turnaround cycle before re-arbitrating. A grantee that never starts
// its transaction within TIMEOUT cycles loses the grant.
// Ports:
//   clk    in  1 - system clock, rising edge
//   resetH in  1 - synchronous active-high reset
//   bus    slave modport of bus_arbiter_if (req/AddrValid/rw in,
//          gnt/owner/busy/timeout out)
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int BURST   = BURST_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          resetH,
    bus_arbiter_if.slave  bus
);

    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (BURST > TIMEOUT) ? BURST : TIMEOUT;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    arb_state_t      state;
    logic [NREQ-1:0] gnt_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   last_owner;
    logic            timeout_q;
    logic [CW-1:0]   wcnt;
    logic [CW-1:0]   bcnt;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_onehot;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req        (bus.req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick_idx),
        .onehot     (pick_onehot)
    );

    // The read/write direction is carried by the RDWAIT-vs-DATA branch taken
    // in GRANT, so no separate rw register is needed.
    always_ff @(posedge clk) begin
        if (resetH) begin
            state      <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            last_owner <= IW'(NREQ - 1);
            timeout_q  <= 1'b0;
            wcnt       <= '0;
            bcnt       <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q      <= pick_onehot;
                        owner_q    <= pick_idx;
                        last_owner <= pick_idx;
                        wcnt       <= '0;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.AddrValid) begin
                        bcnt  <= '0;
                        state <= bus.rw ? RDWAIT : DATA;
                    end else if (!bus.req[owner_q]) begin
                        gnt_q <= '0;
                        state <= IDLE;
                    end else if (wcnt == CW'(TIMEOUT - 1)) begin
                        gnt_q     <= '0;
                        timeout_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                RDWAIT: begin
                    state <= DATA;
                end
                DATA: begin
                    if (bcnt == CW'(BURST - 1)) begin
                        gnt_q <= '0;
                        state <= TURN;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    gnt_q <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = (state != IDLE);
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (NREQ=2, BURST=4, TIMEOUT=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they reflect the edge just taken.
module tb_bus_arbiter;

    logic clk;
    logic resetH;
    int   n_cmp;
    int   n_err;

    bus_arbiter_if #(.NREQ(2)) bus ();

    bus_arbiter #(
        .NREQ    (2),
        .BURST   (4),
        .TIMEOUT (8)
    ) u_dut (
        .clk    (clk),
        .resetH (resetH),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rr_exp [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        resetH        = 1'b1;
        bus.req       = '0;
        bus.AddrValid = 1'b0;
        bus.rw        = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_owner", 32'(bus.owner), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_timeout", 32'(bus.timeout), 32'h0);
        resetH = 1'b0;

        // Write burst: requester 0 wins first after reset
        bus.req = 2'b01;
        tick();
        chk("wr_gnt", 32'(bus.gnt), 32'h1);
        chk("wr_owner", 32'(bus.owner), 32'h0);
        chk("wr_busy", 32'(bus.busy), 32'h1);
        bus.AddrValid = 1'b1;
        bus.rw        = 1'b0;
        tick();
        bus.AddrValid = 1'b0;
        bus.req       = 2'b00;
        chk("wr_gnt_a", 32'(bus.gnt), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("wr_gnt_hold", 32'(bus.gnt), 32'h1);
        end
        tick();
        chk("wr_gnt_drop", 32'(bus.gnt), 32'h0);
        chk("wr_busy_turn", 32'(bus.busy), 32'h1);
        tick();
        chk("wr_busy_idle", 32'(bus.busy), 32'h0);

        // Read burst: one extra RDWAIT cycle before the data beats
        bus.req = 2'b01;
        tick();
        chk("rd_gnt", 32'(bus.gnt), 32'h1);
        bus.AddrValid = 1'b1;
        bus.rw        = 1'b1;
        tick();
        bus.AddrValid = 1'b0;
        bus.rw        = 1'b0;
        bus.req       = 2'b00;
        chk("rd_gnt_a", 32'(bus.gnt), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("rd_gnt_hold", 32'(bus.gnt), 32'h1);
            chk("rd_owner", 32'(bus.owner), 32'h0);
        end
        tick();
        chk("rd_gnt_drop", 32'(bus.gnt), 32'h0);
        tick();
        chk("rd_busy_idle", 32'(bus.busy), 32'h0);

        // Contention: last owner is 0, so requester 1 is next, then alternate
        bus.req = 2'b11;
        for (int b = 0; b < 4; b++) begin
            tick();
            chk("rr_gnt", 32'(bus.gnt), 32'(rr_exp[b]));
            bus.AddrValid = 1'b1;
            bus.rw        = 1'b0;
            tick();
            bus.AddrValid = 1'b0;
            for (int i = 1; i <= 3; i++) begin
                tick();
                chk("rr_gnt_hold", 32'(bus.gnt), 32'(rr_exp[b]));
            end
            tick();
            chk("rr_gnt_turn", 32'(bus.gnt), 32'h0);
            tick();
            chk("rr_gnt_idle", 32'(bus.gnt), 32'h0);
            chk("rr_busy_idle", 32'(bus.busy), 32'h0);
        end
        bus.req = 2'b00;

        // Timeout: requester 1 granted and never strobes AddrValid
        bus.req = 2'b10;
        tick();
        chk("to_gnt", 32'(bus.gnt), 32'h2);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("to_gnt_hold", 32'(bus.gnt), 32'h2);
            chk("to_pulse_low", 32'(bus.timeout), 32'h0);
        end
        bus.req = 2'b11;
        tick();
        chk("to_gnt_drop", 32'(bus.gnt), 32'h0);
        chk("to_pulse", 32'(bus.timeout), 32'h1);
        chk("to_busy", 32'(bus.busy), 32'h0);
        tick();
        chk("to_pulse_end", 32'(bus.timeout), 32'h0);
        chk("to_regrant", 32'(bus.gnt), 32'h1);
        chk("to_regrant_owner", 32'(bus.owner), 32'h0);

        // Withdrawal: owner 0 drops its request while in GRANT
        bus.req = 2'b10;
        tick();
        chk("wd_gnt", 32'(bus.gnt), 32'h0);
        chk("wd_timeout", 32'(bus.timeout), 32'h0);
        chk("wd_busy", 32'(bus.busy), 32'h0);
        bus.req = 2'b00;
        tick();
        chk("wd_idle", 32'(bus.gnt), 32'h0);

        // Reset mid-DATA with requester 1 owning the bus
        bus.req = 2'b10;
        tick();
        chk("rs_gnt", 32'(bus.gnt), 32'h2);
        chk("rs_owner", 32'(bus.owner), 32'h1);
        bus.AddrValid = 1'b1;
        bus.rw        = 1'b0;
        tick();
        bus.AddrValid = 1'b0;
        tick();
        resetH = 1'b1;
        tick();
        chk("rs_gnt_clr", 32'(bus.gnt), 32'h0);
        chk("rs_busy_clr", 32'(bus.busy), 32'h0);
        chk("rs_owner_clr", 32'(bus.owner), 32'h0);
        resetH  = 1'b0;
        bus.req = 2'b11;
        tick();
        chk("rs_first_gnt", 32'(bus.gnt), 32'h1);
        chk("rs_first_owner", 32'(bus.owner), 32'h0);
        bus.req = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
